// File: rtl/servant_uart_pkg.sv
// servant_uart_pkg: shared FSM encoding, frame constants and baud helper for the servant UART.
package servant_uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/servant_uart_rx_fifo.sv
// servant_uart_rx_fifo: first-word-fall-through receive buffer with registered head data.
module servant_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic w_wr, w_rd;
  logic [AW:0] w_rptr_nxt;
  assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = r_wptr == r_rptr;
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_rd};
  assign o_data = r_dout;
  always_ff @(posedge wb_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
  // Head register bypasses the memory when the incoming byte lands in the slot about to be read.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
    end else begin
      r_wptr <= r_wptr + {{AW{1'b0}}, w_wr};
      r_rptr <= w_rptr_nxt;
      r_dout <= (w_wr && r_wptr[AW-1:0] == w_rptr_nxt[AW-1:0]) ? i_data : r_mem[w_rptr_nxt[AW-1:0]];
    end
  end
endmodule

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 receiver for the servant serial output, buffering bytes in a small FIFO.
import servant_uart_pkg::*;
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 556,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  state_t r_state, w_state_nxt;
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic r_frame_err, r_overflow;
  logic w_rxs, w_clr, w_sample, w_push, w_ferr, w_full, w_empty, w_pop;
  assign w_rxs = r_sync[1];
  assign w_pop = ~w_empty & i_ready;
  assign o_valid = ~w_empty;
  assign o_busy = r_state != S_IDLE;
  assign o_frame_err = r_frame_err;
  assign o_overflow = r_overflow;
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    w_clr = 1'b0;
    w_sample = 1'b0;
    w_push = 1'b0;
    w_ferr = 1'b0;
    case (r_state)
      S_IDLE: if (!w_rxs) begin
        w_state_nxt = S_START;
        w_clr = 1'b1;
      end
      S_START: if (r_cnt == HALF_M1) begin
        w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        w_clr = 1'b1;
      end
      S_DATA: if (r_cnt == LAST) begin
        w_sample = 1'b1;
        w_clr = 1'b1;
        w_state_nxt = (r_bit == 3'(DATA_BITS - 1)) ? S_STOP : S_DATA;
      end
      S_STOP: if (r_cnt == LAST) begin
        w_state_nxt = w_rxs ? S_IDLE : S_BREAK;
        w_push = w_rxs;
        w_ferr = ~w_rxs;
      end
      S_BREAK: if (w_rxs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // Bit index wraps back to zero after the eighth sample, so it needs no explicit clear.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_sync <= 2'b11;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_frame_err <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_cnt <= w_clr ? '0 : r_cnt + 1'b1;
      r_bit <= w_sample ? r_bit + 1'b1 : r_bit;
      r_shift <= w_sample ? {w_rxs, r_shift[7:1]} : r_shift;
      r_frame_err <= w_ferr;
      r_overflow <= r_overflow | (w_push & w_full & ~w_pop);
    end
  end
  servant_uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .i_push (w_push),
    .i_data (r_shift),
    .o_full (w_full),
    .i_pop  (w_pop),
    .o_empty(w_empty),
    .o_data (o_data)
  );
endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: directed 8N1 frames against servant_uart_rx with 16 clocks per bit.
module tb_servant_uart_rx;
  logic wb_clk = 1'b0, wb_rst = 1'b0, i_rx = 1'b1, i_ready = 1'b0;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_overflow, o_busy;
  logic ready_lvl = 1'b0;
  int vectors = 0, errors = 0, fe_cnt = 0;

  always #5 wb_clk = ~wb_clk;
  always @(negedge wb_clk) if (o_frame_err === 1'b1) fe_cnt++;

  servant_uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  function automatic logic line_bit(input logic [7:0] b, input logic stop_bit, input int k);
    return k < 16 ? 1'b0 : k < 144 ? b[(k - 16) / 16] : stop_bit;
  endfunction

  // Negedge k of the frame: sample outputs, then drive the line; pop_at pulses i_ready for one cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at,
                            output int v_idx, output logic [7:0] v_data);
    v_idx = -1;
    v_data = '0;
    for (int k = 0; k < 160; k++) begin
      @(negedge wb_clk);
      if (v_idx < 0 && o_valid === 1'b1) begin
        v_idx = k;
        v_data = o_data;
      end
      i_rx = line_bit(b, stop_bit, k);
      i_ready = ready_lvl | (k == pop_at);
    end
  endtask

  task automatic apply_reset();
    @(negedge wb_clk);
    wb_rst = 1'b1;
    i_rx = 1'b1;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (4) @(negedge wb_clk);
  endtask

  task automatic test_reset();
    #1 wb_rst = 1'b1;
    #1;
    vectors++;
    if ({o_valid, o_frame_err, o_overflow, o_busy, o_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b fe=%b ov=%b busy=%b data=%h, expected all 0",
               o_valid, o_frame_err, o_overflow, o_busy, o_data);
    end
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (4) @(negedge wb_clk);
    vectors++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_single();
    int idx, fe0;
    logic [7:0] d;
    fe0 = fe_cnt;
    ready_lvl = 1'b1;
    send_frame(8'h55, 1'b1, -1, idx, d);
    vectors++;
    if (idx !== 155) begin
      errors++;
      $display("FAIL single_latency: o_valid rose at frame cycle %0d, expected 155", idx);
    end
    vectors++;
    if (d !== 8'h55) begin
      errors++;
      $display("FAIL single_data: got %h expected 55", d);
    end
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_popped: got valid=%b busy=%b expected 0 0", o_valid, o_busy);
    end
    vectors++;
    if (fe_cnt != fe0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_flags: got fe_pulses=%0d ov=%b expected 0 0", fe_cnt - fe0, o_overflow);
    end
    ready_lvl = 1'b0;
    i_ready = 1'b0;
  endtask

  task automatic test_glitch();
    int fe0;
    logic busy_seen;
    fe0 = fe_cnt;
    busy_seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge wb_clk);
      if (o_busy === 1'b1) busy_seen = 1'b1;
      i_rx = k < 2 ? 1'b0 : 1'b1;
    end
    vectors++;
    if (busy_seen !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got seen=%b now=%b expected 1 0", busy_seen, o_busy);
    end
    vectors++;
    if (o_valid !== 1'b0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL glitch_quiet: got valid=%b fe_pulses=%0d expected 0 0", o_valid, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err();
    int idx, fe0;
    logic [7:0] d;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, -1, idx, d);
    repeat (24) @(negedge wb_clk);
    vectors++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL ferr_break: got busy=%b valid=%b expected 1 0", o_busy, o_valid);
    end
    i_rx = 1'b1;
    repeat (6) @(negedge wb_clk);
    vectors++;
    if (fe_cnt - fe0 != 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pulse: got pulses=%0d busy=%b expected 1 0", fe_cnt - fe0, o_busy);
    end
    send_frame(8'h7E, 1'b1, -1, idx, d);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 8'h7E) begin
      errors++;
      $display("FAIL ferr_next_byte: got valid=%b data=%h expected 1 7e", o_valid, o_data);
    end
    i_ready = 1'b1;
    @(negedge wb_clk);
    i_ready = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL ferr_after_pop: got valid=%b pulses=%0d expected 0 1", o_valid, fe_cnt - fe0);
    end
  endtask

  task automatic test_overflow();
    int idx;
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, idx, d);
      if (i == 4) begin
        vectors++;
        if (o_overflow !== 1'b0 || o_valid !== 1'b1) begin
          errors++;
          $display("FAIL ovf_at_full: got ov=%b valid=%b expected 0 1", o_overflow, o_valid);
        end
      end
    end
    vectors++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", o_overflow);
    end
    i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d: got valid=%b data=%h expected 1 %h", i, o_valid, o_data, 8'(i));
      end
      @(negedge wb_clk);
    end
    i_ready = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: got valid=%b ov=%b expected 0 1", o_valid, o_overflow);
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    logic [7:0] d;
    send_frame(8'h99, 1'b1, -1, idx, d);
    for (int k = 0; k < 72; k++) begin
      @(negedge wb_clk);
      i_rx = line_bit(8'hC4, 1'b1, k);
    end
    #2 wb_rst = 1'b1;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_fifo: got valid=%b data=%h expected 0 00", o_valid, o_data);
    end
    vectors++;
    if (o_busy !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_fsm: got busy=%b fe=%b expected 0 0", o_busy, o_frame_err);
    end
    vectors++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ovf: got %b expected 0", o_overflow);
    end
    i_rx = 1'b1;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);
    send_frame(8'h3C, 1'b1, -1, idx, d);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      errors++;
      $display("FAIL rstmid_next: got valid=%b data=%h expected 1 3c", o_valid, o_data);
    end
    i_ready = 1'b1;
    @(negedge wb_clk);
    i_ready = 1'b0;
    vectors++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flushed: got valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_full_push_pop();
    int idx;
    logic [7:0] d;
    apply_reset();
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, -1, idx, d);
    send_frame(8'h15, 1'b1, 154, idx, d);
    vectors++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_ovf: got %b expected 0", o_overflow);
    end
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_data !== 8'h12 + 8'(i)) begin
        errors++;
        $display("FAIL pushpop_pop%0d: got valid=%b data=%h expected 1 %h", i, o_valid, o_data, 8'h12 + 8'(i));
      end
      @(negedge wb_clk);
    end
    i_ready = 1'b0;
    vectors++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_drained: got valid=%b expected 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_reset_mid();
    test_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
